two_d_fir: RTL and testbench
============================

// Module: two_d_fir
// PURPOSE
//  Streaming 2-D separable 3x3 FIR filter for 8-bit raster-order pixels. Vertical 3-tap pass over two
//  line buffers, then horizontal 3-tap pass. Emits valid-region pixels only: (H-2)x(V-2) outputs per frame.
//  Sits between a pixel source and a downstream image sink; coefficients and frame size are quasi-static.
// PARAMETERS
//  DATA_WIDTH   8     pixel width, unsigned, in and out
//  ADDR_WIDTH   32    width of h_size_i / v_size_i and internal row/column counters
//  TAP_NUMS     3     taps per direction; only 3 supported
//  COEFF_WIDTH  14    unsigned coefficient width, Q2.12 (0x1000 = 1.0)
//  PIXEL_NUM    1024  line-buffer depth = maximum supported h_size_i
//  REPEAT_NUN   2     number of line buffers; must equal TAP_NUMS-1
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            synchronous, active-high reset
//  ce_i         in   1            input pixel strobe; data_i accepted on clk edge when ce_i=1
//  ready_o      out  1            0 while rst=1, else 1 (block never back-pressures)
//  data_i       in   DATA_WIDTH   input pixel, raster order
//  coeff00_v_i  in   COEFF_WIDTH  vertical tap, row r-2 (oldest line)
//  coeff10_v_i  in   COEFF_WIDTH  vertical tap, row r-1 (centre)
//  coeff20_v_i  in   COEFF_WIDTH  vertical tap, row r (current line)
//  coeff00_h_i  in   COEFF_WIDTH  horizontal tap, column c-2
//  coeff01_h_i  in   COEFF_WIDTH  horizontal tap, column c-1 (centre)
//  coeff02_h_i  in   COEFF_WIDTH  horizontal tap, column c
//  h_size_i     in   ADDR_WIDTH   pixels per line, 3..PIXEL_NUM
//  v_size_i     in   ADDR_WIDTH   lines per frame, >=3
//  valid_o      out  1            data_o qualifier, one-cycle pulse per output pixel
//  data_o       out  DATA_WIDTH   filtered pixel
// BEHAVIOUR
//  - Reset: valid_o=0, data_o=0, ready_o=0, col/row counters=0, pipeline valid tags cleared. Line-buffer
//    contents need not be cleared. Reset mid-frame aborts the frame; next accepted pixel is (row0,col0).
//  - Counters advance only on ce_i. col wraps at h_size_i-1 -> 0 and row++; row wraps at v_size_i-1 -> 0.
//  - h_size_i/v_size_i sampled when pixel (0,0) is accepted; held for the whole frame.
//  - Line buffers: two PIXEL_NUM-deep RAMs addressed by col, written only on ce_i (cascade: lb1<=lb0<=data_i).
//  - Vertical: v = round(c00v*p[r-2][c] + c10v*p[r-1][c] + c20v*p[r][c]) >> 12; full-precision sum
//    (DATA_WIDTH+COEFF_WIDTH+2 bits), round half-up (+0x800), saturate to 0..255.
//  - Horizontal on 3-deep shift register of v values (shifts on accepted pixels only; cleared at col=0):
//    out = sat(round(c00h*v[c-2] + c01h*v[c-1] + c02h*v[c]) >> 12), same rounding/saturation rules.
//  - Output produced only when accepted pixel has row>=2 and col>=2; it is centre pixel (row-1,col-1).
//  - Latency: valid_o asserted exactly 4 clk after the accepting edge; post-acceptance stages free-run, so
//    ce_i gaps do not alter latency or corrupt the window. Back-to-back ce_i -> back-to-back valid_o.
//  - Coefficient changes take effect on next accepted pixel; change mid-frame is legal, no glitch rules.
//  - h_size_i<3 or v_size_i<3: pixels consumed, no valid_o. h_size_i>PIXEL_NUM: undefined, not checked.
//  - Frame end: no flush; last output is for pixel (V-2,H-2). Next frame starts without gap.
// CONFIGURATION
//  - Macro FIR_BYPASS_EN defined: adds input port bypass_i (1 bit). bypass_i=1 -> data_o = unfiltered
//    centre pixel p[row-1][col-1], same valid_o timing and 4-cycle latency. bypass_i=0 -> normal filtering.
//  - Macro undefined: no bypass_i port, filter path always active.
// TESTING
//  1. rst=1 for 2 clk -> valid_o=0, data_o=0, ready_o=0; after release ready_o=1.
//  2. 64x64 frame, all pixels=1, coeffs v/h = 0x500,0x1000,0x500 -> 62*62 outputs, every data_o=3
//     (vertical 1.625->2, horizontal 3.25->3), first valid_o 4 clk after pixel (2,2) accepted.
//  3. Same frame, all pixels=100 -> vertical 163, horizontal 264.9 saturates -> every data_o=255.
//  4. Identity coeffs (0,0x1000,0) both dirs, ramp pixel=(row*8+col)&0xFF, 8x8 -> 36 outputs,
//     data_o = value at (row-1,col-1), exact raster order.
//  5. Case 2 with ce_i toggling 1/0 each cycle -> same 3844 outputs/values; valid_o pulses spaced 2 clk.
//  6. rst pulsed mid-row of frame row 10, then fresh 4x4 frame of 1s -> exactly 4 outputs, all=3.

Source files
------------

// File: rtl/two_d_fir_if.sv
// Pixel stream bundle between source, two_d_fir and sink: input strobe/data, ready, output valid/data.
// The filter consumes through the slave modport; the source/sink side uses the master modport.
interface two_d_fir_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  ce_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  ready_o;
    logic                  valid_o;
    logic [DATA_WIDTH-1:0] data_o;

    modport master (
        output ce_i,
        output data_i,
        input  ready_o,
        input  valid_o,
        input  data_o
    );

    modport slave (
        input  ce_i,
        input  data_i,
        output ready_o,
        output valid_o,
        output data_o
    );
endinterface

// File: rtl/two_d_fir.sv
// Streaming separable 3x3 FIR (vertical over two line buffers, then horizontal); 4 clk latency, never stalls.
// Optional FIR_BYPASS_EN adds bypass_i, which passes the unfiltered centre pixel with identical timing.
module two_d_fir #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int TAP_NUMS    = 3,
    parameter int COEFF_WIDTH = 14,
    parameter int PIXEL_NUM   = 1024,
    parameter int REPEAT_NUN  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    two_d_fir_if.slave             px,
    input  logic [COEFF_WIDTH-1:0] coeff00_v_i,
    input  logic [COEFF_WIDTH-1:0] coeff10_v_i,
    input  logic [COEFF_WIDTH-1:0] coeff20_v_i,
    input  logic [COEFF_WIDTH-1:0] coeff00_h_i,
    input  logic [COEFF_WIDTH-1:0] coeff01_h_i,
    input  logic [COEFF_WIDTH-1:0] coeff02_h_i,
    input  logic [ADDR_WIDTH-1:0]  h_size_i,
`ifdef FIR_BYPASS_EN
    input  logic                   bypass_i,
`endif
    input  logic [ADDR_WIDTH-1:0]  v_size_i
);
    localparam int LBA  = $clog2(PIXEL_NUM);
    localparam int FRAC = 12;
    localparam int SW   = DATA_WIDTH + COEFF_WIDTH + 2;

    if (TAP_NUMS != 3 || REPEAT_NUN != TAP_NUMS - 1) begin : g_bad_cfg
        $error("two_d_fir supports only a 3-tap kernel with two line buffers");
    end

    function automatic logic [DATA_WIDTH-1:0] round_sat(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s + SW'(1 << (FRAC - 1));
        if (|r[SW-1:FRAC+DATA_WIDTH]) return '1;
        return r[FRAC+DATA_WIDTH-1:FRAC];
    endfunction

    logic [DATA_WIDTH-1:0] lb0_q [PIXEL_NUM];
    logic [DATA_WIDTH-1:0] lb1_q [PIXEL_NUM];
    logic [LBA-1:0]        lb_addr;

    logic [ADDR_WIDTH-1:0] col_q, col_d, row_q, row_d, hsz_q, hsz_d, vsz_q, vsz_d;
    logic                  first, last_col, last_row, out_en;

    logic                  s1_vld_q, s1_out_q, s1_col0_q;
    logic                  s2_vld_q, s2_out_q, s2_col0_q;
    logic                  s3_out_q, s4_out_q, valid_q;
    logic [DATA_WIDTH-1:0] s1_pr0_q, s1_pr1_q, s1_pr2_q;
    logic [SW-1:0]         vsum_q, hsum_q;
    logic [DATA_WIDTH-1:0] v_c0_q, v_c1_q, v_c2_q, v_new;
    logic [DATA_WIDTH-1:0] data_q, out_pix;

    // Frame size is latched with pixel (0,0) so the whole frame uses one geometry.
    always_comb begin
        first    = (col_q == '0) && (row_q == '0);
        hsz_d    = first ? h_size_i : hsz_q;
        vsz_d    = first ? v_size_i : vsz_q;
        last_col = ({1'b0, col_q} + 1'b1) >= {1'b0, hsz_d};
        last_row = ({1'b0, row_q} + 1'b1) >= {1'b0, vsz_d};
        col_d    = col_q + 1'b1;
        row_d    = row_q;
        if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + 1'b1;
        end
        out_en   = (row_q >= ADDR_WIDTH'(2)) && (col_q >= ADDR_WIDTH'(2));
    end

    assign lb_addr = col_q[LBA-1:0];
    assign v_new   = round_sat(vsum_q);

`ifdef FIR_BYPASS_EN
    logic [DATA_WIDTH-1:0] cen_s2_q, cen_c0_q, cen_c1_q, cen_s4_q;
    assign out_pix = bypass_i ? cen_s4_q : round_sat(hsum_q);
`else
    assign out_pix = round_sat(hsum_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            hsz_q     <= '0;
            vsz_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_out_q  <= 1'b0;
            s1_col0_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_out_q  <= 1'b0;
            s2_col0_q <= 1'b0;
            s3_out_q  <= 1'b0;
            s4_out_q  <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            if (px.ce_i) begin
                col_q <= col_d;
                row_q <= row_d;
                hsz_q <= hsz_d;
                vsz_q <= vsz_d;
            end
            s1_vld_q  <= px.ce_i;
            s1_out_q  <= px.ce_i & out_en;
            s1_col0_q <= (col_q == '0);
            s2_vld_q  <= s1_vld_q;
            s2_out_q  <= s1_out_q;
            s2_col0_q <= s1_col0_q;
            s3_out_q  <= s2_out_q;
            s4_out_q  <= s3_out_q;
            valid_q   <= s4_out_q;
            if (s4_out_q) data_q <= out_pix;
        end
    end

    // Read-first line buffers: the read returns the pixel one/two lines above before the cascade shift.
    always_ff @(posedge clk) begin
        if (px.ce_i) begin
            lb0_q[lb_addr] <= px.data_i;
            lb1_q[lb_addr] <= lb0_q[lb_addr];
            s1_pr0_q       <= px.data_i;
            s1_pr1_q       <= lb0_q[lb_addr];
            s1_pr2_q       <= lb1_q[lb_addr];
        end
        vsum_q <= SW'(coeff00_v_i) * SW'(s1_pr2_q)
                + SW'(coeff10_v_i) * SW'(s1_pr1_q)
                + SW'(coeff20_v_i) * SW'(s1_pr0_q);
        if (s2_vld_q) begin
            v_c0_q <= v_new;
            v_c1_q <= s2_col0_q ? '0 : v_c0_q;
            v_c2_q <= s2_col0_q ? '0 : v_c1_q;
        end
        hsum_q <= SW'(coeff00_h_i) * SW'(v_c2_q)
                + SW'(coeff01_h_i) * SW'(v_c1_q)
                + SW'(coeff02_h_i) * SW'(v_c0_q);
`ifdef FIR_BYPASS_EN
        cen_s2_q <= s1_pr1_q;
        if (s2_vld_q) begin
            cen_c0_q <= cen_s2_q;
            cen_c1_q <= s2_col0_q ? '0 : cen_c0_q;
        end
        cen_s4_q <= cen_c1_q;
`endif
    end

    assign px.ready_o = ~rst;
    assign px.valid_o = valid_q;
    assign px.data_o  = data_q;
endmodule

// File: tb/tb_two_d_fir.sv
// Directed bench for two_d_fir: scoreboard of expected pixels with acceptance cycle, checked on valid_o.
module tb_two_d_fir;
    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] c00v, c10v, c20v, c00h, c01h, c02h;
    logic [31:0] h_size, v_size;
`ifdef FIR_BYPASS_EN
    logic        bypass = 1'b0;
`endif

    two_d_fir_if #(.DATA_WIDTH(8)) px ();

    two_d_fir dut (
        .clk         (clk),
        .rst         (rst),
        .px          (px),
        .coeff00_v_i (c00v),
        .coeff10_v_i (c10v),
        .coeff20_v_i (c20v),
        .coeff00_h_i (c00h),
        .coeff01_h_i (c01h),
        .coeff02_h_i (c02h),
        .h_size_i    (h_size),
`ifdef FIR_BYPASS_EN
        .bypass_i    (bypass),
`endif
        .v_size_i    (v_size)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   nout  = 0;
    bit   mon_en = 1'b1;

    function automatic int pix(input int kind, input int val, input int r, input int c);
        case (kind)
            0:       return val;
            1:       return (r * 8 + c) & 255;
            default: return (r * 37 + c * 11 + r * c * 3) & 255;
        endcase
    endfunction

    function automatic int satr(input longint s);
        longint q;
        q = (s + 2048) >>> 12;
        return (q > 255) ? 255 : int'(q);
    endfunction

    function automatic int vref(input int kind, input int val, input int r, input int c);
        return satr(longint'(c00v) * pix(kind, val, r - 2, c) + longint'(c10v) * pix(kind, val, r - 1, c)
                  + longint'(c20v) * pix(kind, val, r, c));
    endfunction

    function automatic int ref_out(input int kind, input int val, input int r, input int c);
        return satr(longint'(c00h) * vref(kind, val, r, c - 2) + longint'(c01h) * vref(kind, val, r, c - 1)
                  + longint'(c02h) * vref(kind, val, r, c));
    endfunction

    task automatic set_coeffs(input logic [13:0] a, b, c, d, e, f);
        c00v = a; c10v = b; c20v = c;
        c00h = d; c01h = e; c02h = f;
    endtask

    // emode: 0 = constant expc, 1 = raw centre pixel, 2 = arithmetic reference
    task automatic send_frame(input int h, input int v, input int kind, input int val,
                              input int gap, input int emode, input int expc);
        exp_t e;
        h_size = 32'(h);
        v_size = 32'(v);
        nout   = 0;
        for (int r = 0; r < v; r++) begin
            for (int c = 0; c < h; c++) begin
                @(negedge clk);
                px.ce_i   = 1'b1;
                px.data_i = 8'(pix(kind, val, r, c));
                if (r >= 2 && c >= 2) begin
                    e.acc = cyc + 1;
                    case (emode)
                        0:       e.d = 8'(expc);
                        1:       e.d = 8'(pix(kind, val, r - 1, c - 1));
                        default: e.d = 8'(ref_out(kind, val, r, c));
                    endcase
                    sb.push_back(e);
                end
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    px.ce_i   = 1'b0;
                    px.data_i = 8'($urandom);
                end
            end
        end
        @(negedge clk);
        px.ce_i = 1'b0;
    endtask

    task automatic drain(input int want);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL drain_timeout left=%0d required=0", sb.size());
        end
        total++;
        assert (nout === want) else begin
            bad++;
            $error("FAIL out_count got=%0d required=%0d", nout, want);
        end
    endtask

    initial begin
        exp_t e;
        rst       = 1'b1;
        px.ce_i   = 1'b0;
        px.data_i = '0;
        h_size    = 32'd64;
        v_size    = 32'd64;
        set_coeffs(14'h500, 14'h1000, 14'h500, 14'h500, 14'h1000, 14'h500);

        fork
            forever begin
                @(negedge clk);
                if (mon_en && px.valid_o) begin
                    nout++;
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $error("FAIL extra_valid data=%0d required=no output", px.data_o);
                    end else begin
                        e = sb.pop_front();
                        assert (px.data_o === e.d) else begin
                            bad++;
                            $error("FAIL data_o got=%0d required=%0d", px.data_o, e.d);
                        end
                        total++;
                        assert (cyc === e.acc + 4) else begin
                            bad++;
                            $error("FAIL latency got=%0d required=%0d", cyc - e.acc, 4);
                        end
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        assert (px.valid_o === 1'b0) else begin bad++; $error("FAIL rst_valid got=%b required=0", px.valid_o); end
        total++;
        assert (px.data_o === 8'd0) else begin bad++; $error("FAIL rst_data got=%0d required=0", px.data_o); end
        total++;
        assert (px.ready_o === 1'b0) else begin bad++; $error("FAIL rst_ready got=%b required=0", px.ready_o); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        assert (px.ready_o === 1'b1) else begin bad++; $error("FAIL run_ready got=%b required=1", px.ready_o); end

        send_frame(64, 64, 0, 1, 0, 0, 3);
        drain(3844);
        send_frame(64, 64, 0, 100, 0, 0, 255);
        drain(3844);

        set_coeffs(14'h0, 14'h1000, 14'h0, 14'h0, 14'h1000, 14'h0);
        send_frame(8, 8, 1, 0, 0, 1, 0);
        drain(36);

        set_coeffs(14'h500, 14'h1000, 14'h500, 14'h500, 14'h1000, 14'h500);
        send_frame(64, 64, 0, 1, 1, 0, 3);
        drain(3844);

        set_coeffs(14'h300, 14'h900, 14'h400, 14'h200, 14'hC00, 14'h500);
        send_frame(16, 12, 2, 0, 0, 2, 0);
        drain(140);

        send_frame(2, 5, 0, 1, 0, 0, 0);
        drain(0);
        send_frame(5, 2, 0, 1, 0, 0, 0);
        drain(0);

        set_coeffs(14'h500, 14'h1000, 14'h500, 14'h500, 14'h1000, 14'h500);
        mon_en = 1'b0;
        h_size = 32'd64;
        v_size = 32'd64;
        for (int k = 0; k < 10 * 64 + 20; k++) begin
            @(negedge clk);
            px.ce_i   = 1'b1;
            px.data_i = 8'd1;
        end
        @(negedge clk);
        px.ce_i = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        total++;
        assert (px.valid_o === 1'b0) else begin bad++; $error("FAIL midrst_valid got=%b required=0", px.valid_o); end
        total++;
        assert (px.ready_o === 1'b0) else begin bad++; $error("FAIL midrst_ready got=%b required=0", px.ready_o); end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (5) @(negedge clk);
        mon_en = 1'b1;
        send_frame(4, 4, 0, 1, 0, 0, 3);
        drain(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
